// File: rtl/conv_frame_scheduler.sv
// conv_frame_scheduler: walks the interior pixels of the frame in raster order,
// issuing one centre-pixel read per granted cycle and replaying each read
// address as the ALU write strobe a fixed RD_LAT cycles later.
module conv_frame_scheduler #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int AWIDTH = 17,
    parameter int RD_LAT = 2
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        kernel_sel_in,
    input  logic              mem_gnt,
    output logic [1:0]        kernel_sel,
    output logic [AWIDTH-1:0] raddr_alu,
    output logic              rd_en,
    output logic [AWIDTH-1:0] waddr_alu,
    output logic              wen_alu,
    output logic              busy,
    output logic              done
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0]     X_FIRST  = XW'(1);
    localparam logic [XW-1:0]     X_LAST   = XW'(IMG_W - 2);
    localparam logic [YW-1:0]     Y_FIRST  = YW'(1);
    localparam logic [YW-1:0]     Y_LAST   = YW'(IMG_H - 2);
    localparam logic [AWIDTH-1:0] ROW_STEP = AWIDTH'(IMG_W);
    localparam logic [AWIDTH-1:0] ONE      = AWIDTH'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t              r_state, w_next;
    logic [XW-1:0]       r_x;
    logic [YW-1:0]       r_y;
    logic [AWIDTH-1:0]   r_rowbase;
    logic [AWIDTH-1:0]   r_raddr;
    logic [1:0]          r_ksel;
    logic [RD_LAT:1]     r_vld;
    logic [AWIDTH-1:0]   r_apipe [1:RD_LAT];
    logic [RD_LAT:1]     w_src_v;
    logic [AWIDTH-1:0]   w_src_a [1:RD_LAT];
    logic                w_issue, w_last, w_start, w_inflight;

    // The grant qualifies the read in the same cycle; everything else is registered.
    assign w_issue    = (r_state == S_RUN) && mem_gnt;
    assign w_last     = (r_x == X_LAST) && (r_y == Y_LAST);
    assign w_start    = (r_state == S_IDLE) && start && !abort;

    assign rd_en      = w_issue;
    assign raddr_alu  = r_raddr;
    assign kernel_sel = r_ksel;
    assign wen_alu    = r_vld[RD_LAT];
    assign waddr_alu  = r_apipe[RD_LAT];
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);

    // State register.
    always_ff @(posedge sys_clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next state; DRAIN leaves once nothing but the final stage is still valid.
    always_comb begin
        w_next     = r_state;
        w_inflight = 1'b0;
        for (int k = 1; k < RD_LAT; k++) w_inflight = w_inflight | r_vld[k];
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_issue && w_last) w_next = S_DRAIN;
            S_DRAIN: if (!w_inflight) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (abort) w_next = S_IDLE;
    end

    // Pixel scan: address advances by one, row base by IMG_W at each wrap.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_ksel    <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_rowbase <= '0;
            r_raddr   <= '0;
        end else if (w_start) begin
            r_ksel    <= kernel_sel_in;
            r_x       <= X_FIRST;
            r_y       <= Y_FIRST;
            r_rowbase <= ROW_STEP;
            r_raddr   <= ROW_STEP + ONE;
        end else if (w_issue && !w_last) begin
            if (r_x == X_LAST) begin
                r_x       <= X_FIRST;
                r_y       <= r_y + 1'b1;
                r_rowbase <= r_rowbase + ROW_STEP;
                r_raddr   <= r_rowbase + ROW_STEP + ONE;
            end else begin
                r_x     <= r_x + 1'b1;
                r_raddr <= r_raddr + ONE;
            end
        end
    end

    // Source of each pipe stage: stage 1 takes the live read, later stages shift.
    always_comb begin
        w_src_v    = '0;
        w_src_v[1] = w_issue;
        w_src_a[1] = r_raddr;
        for (int k = 2; k <= RD_LAT; k++) begin
            w_src_v[k] = r_vld[k-1];
            w_src_a[k] = r_apipe[k-1];
        end
    end

    // Latency pipe; addresses only move with a valid entry so waddr holds between writes.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_vld <= '0;
            for (int k = 1; k <= RD_LAT; k++) r_apipe[k] <= '0;
        end else begin
            for (int k = 1; k <= RD_LAT; k++) begin
                r_vld[k] <= w_src_v[k] & ~abort;
                if (w_src_v[k] && !abort) r_apipe[k] <= w_src_a[k];
            end
        end
    end

endmodule

// File: tb/tb_conv_frame_scheduler.sv
// Bench for conv_frame_scheduler: a small 6x5 instance checked every cycle
// against an event-level model, plus a full 320x240 instance checked for the
// complete ordered write sequence.
module tb_conv_frame_scheduler;

    localparam int W = 6, H = 5, LAT = 2, AW = 17;
    localparam int NPIX = (W - 2) * (H - 2);
    localparam int FW = 320, FH = 240;
    localparam int FNPIX = (FW - 2) * (FH - 2);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, abort, gnt;
    logic [1:0] ksel_in, ksel;
    logic [AW-1:0] raddr, waddr;
    logic rd_en, wen, busy, done;

    logic f_rst, f_start;
    logic [1:0] f_ksel;
    logic [AW-1:0] f_raddr, f_waddr;
    logic f_rd, f_wen, f_busy, f_done;

    conv_frame_scheduler #(.IMG_W(W), .IMG_H(H), .AWIDTH(AW), .RD_LAT(LAT)) dut (
        .sys_clk(clk), .rst(rst), .start(start), .abort(abort),
        .kernel_sel_in(ksel_in), .mem_gnt(gnt), .kernel_sel(ksel),
        .raddr_alu(raddr), .rd_en(rd_en), .waddr_alu(waddr), .wen_alu(wen),
        .busy(busy), .done(done));

    conv_frame_scheduler #(.IMG_W(FW), .IMG_H(FH), .AWIDTH(AW), .RD_LAT(LAT)) dut_full (
        .sys_clk(clk), .rst(f_rst), .start(f_start), .abort(1'b0),
        .kernel_sel_in(2'd0), .mem_gnt(1'b1), .kernel_sel(f_ksel),
        .raddr_alu(f_raddr), .rd_en(f_rd), .waddr_alu(f_waddr), .wen_alu(f_wen),
        .busy(f_busy), .done(f_done));

    int n_pass = 0, n_chk = 0;
    int cyc = 0;
    bit chk_en = 0, f_chk_en = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Interior pixel index -> frame address, raster order.
    function automatic int pix_addr(input int idx, input int w);
        return (idx / (w - 2) + 1) * w + (idx % (w - 2)) + 1;
    endfunction

    // ---------------- behavioural model of the small instance ----------------
    typedef struct {int cyc; int addr;} wr_t;
    wr_t m_wq[$];
    bit  m_run = 0;
    int  m_next = 0, m_ksel = 0, m_lastw = 0, m_done_cyc = -1, m_busy_end = -1;

    int rd_c[$], rd_a[$], wen_c[$], wen_a[$], done_c[$];
    int last_busy = -1;

    always @(negedge clk) begin
        bit e_rd, e_wen, e_busy;
        int e_ra;
        e_rd  = m_run && gnt;
        e_ra  = pix_addr(m_next, W);
        e_wen = 0;
        if (m_wq.size() > 0 && m_wq[0].cyc == cyc) begin
            e_wen   = 1;
            m_lastw = m_wq[0].addr;
            m_wq.delete(0);
        end
        e_busy = m_run || (cyc <= m_busy_end);
        if (chk_en) begin
            chk("rd_en", rd_en, e_rd);
            if (e_rd) chk("raddr", raddr, e_ra);
            chk("wen", wen, e_wen);
            chk("waddr", waddr, m_lastw);
            chk("busy", busy, e_busy);
            chk("done", done, cyc == m_done_cyc);
            chk("kernel_sel", ksel, m_ksel);
            if (rd_en) begin rd_c.push_back(cyc); rd_a.push_back(int'(raddr)); end
            if (wen) begin wen_c.push_back(cyc); wen_a.push_back(int'(waddr)); end
            if (done) done_c.push_back(cyc);
            if (busy) last_busy = cyc;
        end
        // advance model with the inputs sampled at the coming edge
        if (rst) begin
            m_run = 0; m_wq.delete(); m_ksel = 0; m_lastw = 0;
            m_done_cyc = -1; m_busy_end = -1;
        end else if (abort) begin
            m_run = 0; m_wq.delete(); m_done_cyc = -1; m_busy_end = -1;
        end else begin
            if (e_rd) begin
                m_wq.push_back('{cyc + LAT, e_ra});
                m_next++;
                if (m_next == NPIX) begin
                    m_run = 0;
                    m_done_cyc = cyc + LAT + 1;
                    m_busy_end = m_done_cyc;
                end
            end
            if (start && !e_busy) begin
                m_run = 1; m_next = 0; m_ksel = int'(ksel_in);
            end
        end
        cyc++;
    end

    // ---------------- full-size ordered scoreboard ----------------
    int f_wcnt = 0, f_rcnt = 0, f_first = -1, f_last = -1, f_ndone = 0;
    always @(negedge clk) begin
        if (f_chk_en) begin
            if (f_wen) begin
                chk("full_waddr", f_waddr, pix_addr(f_wcnt, FW));
                if (f_wcnt == 0) f_first = int'(f_waddr);
                f_last = int'(f_waddr);
                f_wcnt++;
            end
            if (f_rd) begin
                chk("full_raddr", f_raddr, pix_addr(f_rcnt, FW));
                f_rcnt++;
            end
            if (f_done) f_ndone++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rd_c.delete(); rd_a.delete(); wen_c.delete(); wen_a.delete(); done_c.delete();
    endtask

    int exp_a[NPIX] = '{7, 8, 9, 10, 13, 14, 15, 16, 19, 20, 21, 22};

    initial begin
        int s, abort_at;
        rst = 1; start = 0; abort = 0; gnt = 1; ksel_in = 0;
        f_rst = 1; f_start = 0;
        tick();
        chk_en = 1;
        repeat (2) tick();
        rst = 0; f_rst = 0;
        chk("rst_kernel_sel", ksel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_waddr", waddr, 0);
        tick();

        // 1: plain pass, continuous grant
        clear_logs(); s = cyc;
        start = 1; ksel_in = 1; tick(); start = 0;
        repeat (20) tick();
        chk("t1_rd_cnt", rd_c.size(), 12);
        for (int i = 0; i < 12 && i < rd_c.size(); i++) begin
            chk("t1_rd_cyc", rd_c[i] - s, i + 1);
            chk("t1_raddr", rd_a[i], exp_a[i]);
        end
        chk("t1_wen_cnt", wen_c.size(), 12);
        for (int i = 0; i < 12 && i < wen_c.size(); i++) begin
            chk("t1_wen_cyc", wen_c[i] - s, i + 3);
            chk("t1_waddr", wen_a[i], exp_a[i]);
        end
        chk("t1_done_cnt", done_c.size(), 1);
        if (done_c.size() > 0) chk("t1_done_cyc", done_c[0] - s, 15);
        chk("t1_last_busy", last_busy - s, 15);

        // 2: grant withheld on cycles 4..6
        clear_logs(); s = cyc;
        for (int r = 0; r < 25; r++) begin
            start = (r == 0);
            gnt = !(r >= 4 && r <= 6);
            tick();
        end
        start = 0; gnt = 1;
        chk("t2_rd_cnt", rd_c.size(), 12);
        for (int i = 0; i < 12 && i < rd_c.size(); i++) begin
            chk("t2_rd_cyc", rd_c[i] - s, (i < 3) ? i + 1 : i + 4);
            chk("t2_raddr", rd_a[i], exp_a[i]);
        end
        chk("t2_wen_cnt", wen_c.size(), 12);
        for (int i = 0; i < 12 && i < wen_c.size(); i++) chk("t2_waddr", wen_a[i], exp_a[i]);
        chk("t2_done_cnt", done_c.size(), 1);
        if (done_c.size() > 0) chk("t2_done_cyc", done_c[0] - s, 18);

        // 3: kernel select latched at start; mid-pass start ignored
        clear_logs(); s = cyc;
        for (int r = 0; r < 22; r++) begin
            start = (r == 0) || (r == 5);
            ksel_in = (r == 0) ? 2'd2 : 2'd1;
            tick();
            if (r == 10) chk("t3_kernel_sel", ksel, 2);
        end
        start = 0;
        chk("t3_rd_cnt", rd_c.size(), 12);
        chk("t3_done_cnt", done_c.size(), 1);
        if (done_c.size() > 0) chk("t3_done_cyc", done_c[0] - s, 15);

        // 4: abort at cycle 6, then a clean pass
        clear_logs(); s = cyc;
        for (int r = 0; r < 14; r++) begin
            start = (r == 0);
            abort = (r == 6);
            tick();
        end
        abort = 0;
        chk("t4_wen_cnt", wen_c.size(), 4);
        if (wen_c.size() > 0) chk("t4_last_wen", wen_c[wen_c.size()-1] - s, 6);
        chk("t4_done_cnt", done_c.size(), 0);
        chk("t4_last_busy", last_busy - s, 6);
        clear_logs();
        start = 1; tick(); start = 0;
        repeat (20) tick();
        chk("t4b_wen_cnt", wen_c.size(), 12);
        for (int i = 0; i < 12 && i < wen_a.size(); i++) chk("t4b_waddr", wen_a[i], exp_a[i]);
        chk("t4b_done_cnt", done_c.size(), 1);

        // 5: reset mid-pass
        clear_logs(); s = cyc;
        for (int r = 0; r < 9; r++) begin
            start = (r == 0);
            ksel_in = 2'd3;
            rst = (r == 8);
            tick();
        end
        rst = 0; start = 0;
        chk("t5_rd_en", rd_en, 0);
        chk("t5_wen", wen, 0);
        chk("t5_waddr", waddr, 0);
        chk("t5_raddr", raddr, 0);
        chk("t5_kernel_sel", ksel, 0);
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        repeat (10) tick();
        chk("t5_done_cnt", done_c.size(), 0);

        // abort and start together in IDLE: no pass
        start = 1; abort = 1; tick();
        start = 0; abort = 0;
        chk("abort_start_busy", busy, 0);
        tick();
        chk("abort_start_busy2", busy, 0);

        // randomized passes: grant gaps, stray starts, occasional abort
        for (int p = 0; p < 8; p++) begin
            abort_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 25)) : -1;
            for (int r = 0; r < 60; r++) begin
                start = (r == 0) || ($urandom_range(0, 15) == 0);
                abort = (r == abort_at);
                gnt = ($urandom_range(0, 9) < 7);
                ksel_in = 2'($urandom_range(0, 3));
                tick();
            end
            start = 0; abort = 0; gnt = 1;
            for (int i = 0; i < 40 && busy; i++) tick();
            chk("rand_idle", busy, 0);
        end

        // 6: full-size pass
        f_chk_en = 1;
        f_start = 1; tick(); f_start = 0;
        for (int i = 0; i < 80000 && f_ndone == 0; i++) tick();
        repeat (3) tick();
        chk("full_done_cnt", f_ndone, 1);
        chk("full_wcnt", f_wcnt, FNPIX);
        chk("full_rcnt", f_rcnt, FNPIX);
        chk("full_first", f_first, 321);
        chk("full_last", f_last, 76478);
        chk("full_idle", f_busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
